// File: rtl/serial_fifo.sv
// rtl/serial_fifo.sv - RX/TX byte FIFOs between the UART pair and the SerialStat/SerialDate bus decoder (optional SERIAL_FIFO_OVERRUN_CNT_EN)
module serial_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        rx_ready_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_clear_o,
    input  logic        tx_busy_i,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o,
    input  logic        rd_pop_i,
    output logic [7:0]  rd_data_o,
    input  logic        wr_push_i,
    input  logic [7:0]  wr_data_i,
    output logic [31:0] status_o
`ifdef SERIAL_FIFO_OVERRUN_CNT_EN
    ,
    output logic [7:0]  overrun_cnt_o
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic {R_IDLE, R_CLR} rx_state_e;
    typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT, T_DONE} tx_state_e;

    logic [7:0]            rx_mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;
    rx_state_e             rx_state_q, rx_state_d;
    logic                  rx_clear_q, rx_clear_d;

    logic [7:0]            tx_mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d;
    tx_state_e             tx_state_q, tx_state_d;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [1:0]            tx_wait_q, tx_wait_d;

    logic rx_full, rx_empty, rx_capture, rx_pop, rx_push, rx_drop;
    logic tx_full, tx_empty, tx_drain, tx_push;

    // FIFO flags and the accept/drop decisions for each port
    always_comb begin
        rx_full    = (rx_cnt_q == FULL_CNT);
        rx_empty   = (rx_cnt_q == '0);
        rx_capture = (rx_state_q == R_IDLE) && rx_ready_i;
        rx_pop     = rd_pop_i && !rx_empty;
        // A same-cycle pop frees a slot, so a capture into a full FIFO still lands
        rx_push    = rx_capture && (!rx_full || rx_pop);
        rx_drop    = rx_capture && rx_full && !rx_pop;
        tx_full    = (tx_cnt_q == FULL_CNT);
        tx_empty   = (tx_cnt_q == '0);
        tx_drain   = (tx_state_q == T_IDLE) && !tx_empty && !tx_busy_i;
        tx_push    = wr_push_i && (!tx_full || tx_drain);
    end

    // Pointer and occupancy next-state for both FIFOs
    always_comb begin
        rx_wptr_d = rx_push ? rx_wptr_q + 1'b1 : rx_wptr_q;
        rx_rptr_d = rx_pop  ? rx_rptr_q + 1'b1 : rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_push && !rx_pop) begin
            rx_cnt_d = rx_cnt_q + 1'b1;
        end else if (!rx_push && rx_pop) begin
            rx_cnt_d = rx_cnt_q - 1'b1;
        end
        tx_wptr_d = tx_push  ? tx_wptr_q + 1'b1 : tx_wptr_q;
        tx_rptr_d = tx_drain ? tx_rptr_q + 1'b1 : tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_push && !tx_drain) begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end else if (!tx_push && tx_drain) begin
            tx_cnt_d = tx_cnt_q - 1'b1;
        end
    end

    // RX capture FSM: take one byte per ready assertion, hold clear until ready drops
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            R_IDLE:  if (rx_ready_i)  rx_state_d = R_CLR;
            R_CLR:   if (!rx_ready_i) rx_state_d = R_IDLE;
            default: rx_state_d = R_IDLE;
        endcase
        rx_clear_d = (rx_state_d == R_CLR);
    end

    // TX drain FSM: latch head, pulse start, then follow the transmitter's busy flag
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_wait_d  = tx_wait_q;
        case (tx_state_q)
            T_IDLE: begin
                if (tx_drain) begin
                    tx_data_d  = tx_mem[tx_rptr_q];
                    tx_state_d = T_START;
                end
            end
            T_START: begin
                tx_wait_d  = '0;
                tx_state_d = T_WAIT;
            end
            T_WAIT: begin
                // A transmitter that never raises busy must not stall the queue
                if (tx_busy_i) begin
                    tx_state_d = T_DONE;
                end else if (tx_wait_q == 2'd3) begin
                    tx_state_d = T_IDLE;
                end else begin
                    tx_wait_d = tx_wait_q + 1'b1;
                end
            end
            T_DONE:  if (!tx_busy_i) tx_state_d = T_IDLE;
            default: tx_state_d = T_IDLE;
        endcase
        tx_start_d = (tx_state_d == T_START);
    end

    // Control state registers
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
            rx_state_q <= R_IDLE;
            rx_clear_q <= 1'b0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_cnt_q   <= '0;
            tx_state_q <= T_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_wait_q  <= '0;
        end else begin
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_state_q <= rx_state_d;
            rx_clear_q <= rx_clear_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_state_q <= tx_state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            tx_wait_q  <= tx_wait_d;
        end
    end

    // Storage arrays; contents are don't-care while the matching count says empty
    always_ff @(posedge clk_50M) begin
        if (rx_push) rx_mem[rx_wptr_q] <= rx_data_i;
        if (tx_push) tx_mem[tx_wptr_q] <= wr_data_i;
    end

`ifdef SERIAL_FIFO_OVERRUN_CNT_EN
    logic [7:0] overrun_q, overrun_d;

    // Saturating count of RX bytes lost to a full FIFO
    always_comb begin
        overrun_d = overrun_q;
        if (rx_drop && overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
    end

    // Overrun counter register, cleared only by reset
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) overrun_q <= 8'h00;
        else        overrun_q <= overrun_d;
    end

    assign overrun_cnt_o = overrun_q;
`else
    logic unused_drop;
    assign unused_drop = rx_drop;
`endif

    assign rx_clear_o = rx_clear_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign rd_data_o  = rx_empty ? 8'h00 : rx_mem[rx_rptr_q];
    assign status_o   = {30'b0, !rx_empty, !tx_full};

endmodule

// File: doc/serial_fifo.md
# serial_fifo

Byte-buffering stage between the UART pair (async_receiver / async_transmitter) and the memory-mapped bus decoder that serves the SerialStat (0xBFD003FC) and SerialDate (0xBFD003F8) addresses. It captures each received byte into an RX FIFO and acknowledges the receiver. It queues CPU-written bytes in a TX FIFO and drains them to the transmitter through a start/busy handshake. The CPU no longer races the receiver's ready flag, and back-to-back SW stores to SerialDate are not lost while the transmitter is busy.

## Interface
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries per direction); legal range 1..8
- clk_50M  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- rx_ready_i  in  1  from async_receiver RxD_data_ready
- rx_data_i  in  8  from async_receiver RxD_data
- rx_clear_o  out  1  to async_receiver RxD_clear
- tx_busy_i  in  1  from async_transmitter TxD_busy
- tx_start_o  out  1  to async_transmitter TxD_start
- tx_data_o  out  8  to async_transmitter TxD_data
- rd_pop_i  in  1  bus pops RX head (one pulse per byte read from SerialDate)
- rd_data_o  out  8  RX head byte (show-ahead); 0x00 when empty
- wr_push_i  in  1  bus pushes a byte (one pulse per SW to SerialDate)
- wr_data_i  in  8  byte to push
- status_o  out  32  {30'b0, rx_avail, tx_room}; same layout as SerialStat
- overrun_cnt_o  out  8  dropped RX bytes (only with SERIAL_FIFO_OVERRUN_CNT_EN)

## Operation
- Each FIFO is a circular buffer with rd/wr pointers of DEPTH_LOG2 bits and a count of DEPTH_LOG2+1 bits. Pointers wrap modulo 2^DEPTH_LOG2. full = (count == 2^DEPTH_LOG2); empty = (count == 0).
- rx_avail = RX count != 0. tx_room = TX count != full.
- RX capture FSM:
  - R_IDLE: on rx_ready_i=1, write rx_data_i if not full, otherwise drop the byte. Go to R_CLR.
  - R_CLR: rx_clear_o=1 (registered). Stay while rx_ready_i=1. Return to R_IDLE in the cycle after rx_ready_i=0, with rx_clear_o=0.
  - A byte is therefore captured exactly once per ready assertion.
- RX pop: rd_pop_i while empty is ignored. Capture and pop in the same cycle are both performed. When full, capture plus pop leaves count unchanged and the byte is accepted, not dropped.
- TX push: wr_push_i while full (and no same-cycle drain) is ignored; the byte is lost. Push and drain in the same cycle are both performed.
- TX drain FSM:
  - T_IDLE: if not empty and tx_busy_i=0, latch the head into tx_data_o, pop it, and go to T_START.
  - T_START: tx_start_o=1 for exactly this cycle. Go to T_WAIT.
  - T_WAIT: wait for tx_busy_i=1, then go to T_DONE. If busy is not seen within 4 cycles, go to T_IDLE; the byte is considered sent.
  - T_DONE: wait for tx_busy_i=0, then go to T_IDLE.
- tx_data_o holds its value from T_START until the next latch.
- Reset: both FIFOs empty, pointers 0, FSMs in R_IDLE/T_IDLE. All outputs 0 except status_o = 32'h1 (tx_room=1). Reset mid-transfer discards all queued bytes and drops tx_start_o and rx_clear_o immediately.

## Timing
- All state is updated on the posedge of clk_50M. rd_data_o and status_o are combinational from registers, with no input-to-output paths.
- RX: if rx_ready_i first goes high in cycle N, the byte is written at the end of N. rx_avail and rd_data_o are valid in N+1. rx_clear_o is high from N+1.
- RX pop: after rd_pop_i in cycle N, the next head or the updated rx_avail is visible in N+1.
- TX: wr_push_i in cycle N gives a nonempty FIFO in N+1. With tx_busy_i=0, the head is latched at the end of N+1 and tx_start_o is high in N+2.
- Sustained TX throughput is one byte per transmitter frame plus 2 cycles of FSM overhead.

## Configuration
- SERIAL_FIFO_OVERRUN_CNT_EN:
  - Defined: an 8-bit saturating counter increments on every RX byte dropped because the FIFO is full. It is cleared by reset only and is driven on overrun_cnt_o.
  - Undefined: the counter and the overrun_cnt_o port are omitted, and drops are silent.

## Test plan
- Reset then idle: status_o=0x00000001, rd_data_o=0x00, tx_start_o=0, rx_clear_o=0.
- Receive 0x41, 0x42, 0x43 (ready held 3 cycles each): exactly one rx_clear_o burst per byte, count=3. Pops return 0x41, 0x42, 0x43, then status_o=0x1.
- Receive 18 bytes with no pops at DEPTH_LOG2=4: first 16 retained in order, bytes 17–18 dropped. overrun_cnt_o=2 with the macro defined.
- Push 0x55, 0xAA back-to-back while the tx_busy_i model holds busy for 10 cycles per start: two tx_start_o pulses, each 1 cycle wide, tx_data_o=0x55 then 0xAA, the second start only after busy falls.
- Fill TX to 16 entries, then push and drain in the same cycle: count stays 16, the pushed byte is later transmitted last, tx_room stays 0 throughout.
- Assert rst_n=0 during T_DONE with 5 bytes in each FIFO: tx_start_o and rx_clear_o are 0 immediately, and after release status_o=0x1 with no further tx_start_o.
